// File: rtl/player_grid_ctrl.sv
// player_grid_ctrl: moves a single player cell around an 8x8 grid under
// frame-paced button control, rejecting moves into walls or off the grid.
module player_grid_ctrl #(
  parameter logic [2:0]  START_X     = 3'd1,
  parameter logic [2:0]  START_Y     = 3'd1,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [63:0] grid_is_wall,
  output logic [2:0]  player_x,
  output logic [2:0]  player_y,
  output logic [63:0] player_mask,
  output logic        busy,
  output logic        bump
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TGT_W   = 4;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned GRID_W  = 64;

  localparam logic [IDX_W-1:0]  START_IDX  = {START_Y, START_X};
  localparam logic [GRID_W-1:0] START_MASK = GRID_W'(1) << START_IDX;
  localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, CHECK, MOVE, HOLD} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t             state, state_next;
  dir_t               dir, pri_dir;
  logic               dir_load;
  logic [CNT_W-1:0]   hold_cnt;
  logic               any_btn;
  logic [TGT_W-1:0]   tgt_x, tgt_y;
  logic [IDX_W-1:0]   tgt_idx;
  logic               blocked;

  assign any_btn = btn_up | btn_down | btn_left | btn_right;

  // Direction priority: up > down > left > right
  always_comb begin
    if (btn_up)        pri_dir = DIR_UP;
    else if (btn_down) pri_dir = DIR_DOWN;
    else if (btn_left) pri_dir = DIR_LEFT;
    else               pri_dir = DIR_RIGHT;
  end

  // Target cell in 4-bit arithmetic; bit 3 set means off-grid (no wrap)
  always_comb begin
    tgt_x = {1'b0, player_x};
    tgt_y = {1'b0, player_y};
    case (dir)
      DIR_UP:    tgt_y = {1'b0, player_y} - TGT_W'(1);
      DIR_DOWN:  tgt_y = {1'b0, player_y} + TGT_W'(1);
      DIR_LEFT:  tgt_x = {1'b0, player_x} - TGT_W'(1);
      DIR_RIGHT: tgt_x = {1'b0, player_x} + TGT_W'(1);
      default:   ;
    endcase
    tgt_idx = {tgt_y[2:0], tgt_x[2:0]};
    blocked = tgt_x[3] | tgt_y[3] | grid_is_wall[tgt_idx];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; direction is latched only on entry to CHECK
  always_comb begin
    state_next = state;
    dir_load   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick && any_btn) begin
          state_next = CHECK;
          dir_load   = 1'b1;
        end
      end
      CHECK: state_next = blocked ? HOLD : MOVE;
      MOVE:  state_next = HOLD;
      HOLD: begin
        if (!any_btn) begin
          state_next = IDLE;
        end else if (frame_tick && (hold_cnt <= CNT_W'(1))) begin
          state_next = CHECK;
          dir_load   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    bump = 1'b0;
    busy = (state != IDLE);
    bump = (state == CHECK) && blocked;
  end

  // Latched move direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           dir <= DIR_UP;
    else if (dir_load) dir <= pri_dir;
  end

  // Auto-repeat frame counter: loaded on HOLD entry, counts frame ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if ((state_next == HOLD) && (state != HOLD)) begin
      hold_cnt <= HOLD_LOAD;
    end else if ((state == HOLD) && frame_tick && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end

  // Player position and one-hot mask, committed on MOVE exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      player_x    <= START_X;
      player_y    <= START_Y;
      player_mask <= START_MASK;
    end else if (state == MOVE) begin
      player_x    <= tgt_x[2:0];
      player_y    <= tgt_y[2:0];
      player_mask <= GRID_W'(1) << tgt_idx;
    end
  end

endmodule

// File: tb/tb_player_grid_ctrl.sv
// tb_player_grid_ctrl: directed bench with a scoreboard of expected positions.
module tb_player_grid_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [3:0]  btns;            // {up, down, left, right}
  logic [63:0] grid_is_wall;
  logic [2:0]  player_x, player_y;
  logic [63:0] player_mask;
  logic        busy, bump;

  int checks = 0;
  int errors = 0;
  int bump_cnt = 0;
  int mx = 1;
  int my = 1;

  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] ox;
    logic [2:0] oy;
    logic       bmp;
  } exp_t;

  exp_t exp_q[$];

  player_grid_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .btn_up      (btns[3]),
    .btn_down    (btns[2]),
    .btn_left    (btns[1]),
    .btn_right   (btns[0]),
    .grid_is_wall(grid_is_wall),
    .player_x    (player_x),
    .player_y    (player_y),
    .player_mask (player_mask),
    .busy        (busy),
    .bump        (bump)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bump === 1'b1) bump_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic logic [63:0] onehot(input int x, input int y);
    logic [63:0] m;
    m = '0;
    m[y*8+x] = 1'b1;
    return m;
  endfunction

  function automatic exp_t model_calc(input logic [3:0] b);
    exp_t e;
    int dx, dy, tx, ty;
    dx = 0; dy = 0;
    if (b[3])      dy = -1;
    else if (b[2]) dy = 1;
    else if (b[1]) dx = -1;
    else           dx = 1;
    tx = mx + dx;
    ty = my + dy;
    e.ox = 3'(mx);
    e.oy = 3'(my);
    if (tx < 0 || tx > 7 || ty < 0 || ty > 7 || grid_is_wall[ty*8+tx]) begin
      e.bmp = 1'b1; e.x = e.ox; e.y = e.oy;
    end else begin
      e.bmp = 1'b0; e.x = 3'(tx); e.y = 3'(ty);
    end
    return e;
  endfunction

  // Single tap: buttons + frame_tick for one cycle, then released during CHECK
  task automatic do_move(input string tag, input logic [3:0] b);
    exp_t e, got;
    int bc;
    e = model_calc(b);
    exp_q.push_back(e);
    bc = bump_cnt;
    @(negedge clk); btns = b; frame_tick = 1'b1;
    @(negedge clk); btns = '0; frame_tick = 1'b0;
    chk({tag, "_bump_in_check"}, 64'(bump), 64'(e.bmp));
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    @(negedge clk);
    chk({tag, "_x_before"}, 64'(player_x), 64'(e.ox));
    @(negedge clk);
    got = exp_q.pop_front();
    chk({tag, "_x"}, 64'(player_x), 64'(got.x));
    chk({tag, "_y"}, 64'(player_y), 64'(got.y));
    chk({tag, "_mask"}, player_mask, onehot(int'(got.x), int'(got.y)));
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    chk({tag, "_bump_count"}, 64'(bump_cnt - bc), 64'(e.bmp));
    mx = int'(got.x);
    my = int'(got.y);
  endtask

  initial begin
    exp_t got;
    int bc;
    rst = 1'b1;
    frame_tick = 1'b0;
    btns = '0;
    grid_is_wall = 64'h0000_0000_0000_0202;   // walls at (1,0) and start cell (1,1)
    repeat (2) @(negedge clk);
    chk("reset_x", 64'(player_x), 64'(1));
    chk("reset_y", 64'(player_y), 64'(1));
    chk("reset_mask", player_mask, onehot(1, 1));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_bump", 64'(bump), 64'(0));
    rst = 1'b0;

    // Frame ticks with no buttons do nothing
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      chk("idle_busy", 64'(busy), 64'(0));
    end
    chk("idle_mask", player_mask, onehot(1, 1));

    do_move("up_wall", 4'b1000);
    do_move("right_open", 4'b0001);
    grid_is_wall = '0;
    do_move("up_over_right", 4'b1001);
    do_move("up_edge", 4'b1000);
    do_move("left_over_right", 4'b0011);
    do_move("left_open", 4'b0010);
    do_move("left_edge", 4'b0010);
    do_move("down_over_lr", 4'b0111);
    do_move("down1", 4'b0100);
    do_move("down2", 4'b0100);
    do_move("left_edge_y3", 4'b0010);
    grid_is_wall = onehot(1, 3);
    do_move("right_wall", 4'b0001);
    grid_is_wall = '0;

    // Auto-repeat: hold down from (0,3)
    exp_q.push_back(model_calc(4'b0100));
    @(negedge clk); btns = 4'b0100; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    chk("rep_first_y", 64'(player_y), 64'(got.y));
    my = int'(got.y);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      @(negedge clk);
      chk("rep_wait_y", 64'(player_y), 64'(4));
      chk("rep_wait_busy", 64'(busy), 64'(1));
    end
    exp_q.push_back(model_calc(4'b0100));
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    chk("rep_second_y", 64'(player_y), 64'(got.y));
    chk("rep_second_mask", player_mask, onehot(int'(got.x), int'(got.y)));
    my = int'(got.y);
    btns = '0;
    @(negedge clk);
    chk("rep_release_idle", 64'(busy), 64'(0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
    chk("rep_no_more_y", 64'(player_y), 64'(5));

    // Reset asserted while in CHECK aborts the move
    bc = bump_cnt;
    @(negedge clk); btns = 4'b0100; frame_tick = 1'b1;
    @(negedge clk); btns = '0; frame_tick = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_check_x", 64'(player_x), 64'(1));
    chk("rst_check_y", 64'(player_y), 64'(1));
    chk("rst_check_mask", player_mask, onehot(1, 1));
    chk("rst_check_busy", 64'(busy), 64'(0));
    chk("rst_check_bump", 64'(bump), 64'(0));
    @(negedge clk); rst = 1'b0;
    mx = 1; my = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_mask", player_mask, onehot(1, 1));
    chk("post_rst_bumps", 64'(bump_cnt - bc), 64'(0));
    do_move("first_after_rst", 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_grid_ctrl.md
PLAYER_GRID_CTRL -- requirements
Module: player_grid_ctrl

Interface
REQ-001 SHALL have parameter START_X, default 3'd1, reset column of player cell.
REQ-002 SHALL have parameter START_Y, default 3'd1, reset row of player cell.
REQ-003 SHALL have parameter HOLD_FRAMES, default 8, frames between auto-repeat moves while a direction is held (range 1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 SHALL have port btn_up, btn_down, btn_left, btn_right  input  1 each  synchronised, level-sensitive direction requests.
REQ-008 SHALL have port grid_is_wall  input  64  wall map; bit y*8+x set = wall cell.
REQ-009 SHALL have port player_x  output  3  current column.
REQ-010 SHALL have port player_y  output  3  current row.
REQ-011 SHALL have port player_mask  output  64  one-hot, bit player_y*8+player_x set, for grid renderer.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port bump  output  1  one-cycle pulse when a requested move is rejected.

Function
REQ-014 FSM states: IDLE, CHECK, MOVE, HOLD.
REQ-015 IDLE -> CHECK on frame_tick=1 with any button high; direction latched that cycle, priority up > down > left > right.
REQ-016 Direction deltas: up y-1, down y+1, left x-1, right x+1; target computed in 4-bit signed-free arithmetic so out-of-range (x or y <0 or >7) is detected, never wrapped.
REQ-017 CHECK (one cycle): target out of range or grid_is_wall[target] = 1 -> bump=1 for that cycle, next HOLD; else next MOVE.
REQ-018 MOVE (one cycle): player_x/player_y/player_mask take target on exit edge; next HOLD.
REQ-019 Latency: position visible 2 clocks after the clk edge sampling frame_tick.
REQ-020 HOLD: frame counter loaded with HOLD_FRAMES on entry, decrements on each frame_tick; all buttons low -> IDLE immediately; counter reaches 0 with a button high -> CHECK using newly latched direction (priority per REQ-015).
REQ-021 Button changes in CHECK/MOVE are ignored; direction is fixed from latch to MOVE exit.
REQ-022 grid_is_wall sampled only in CHECK; changes at other times have no effect on current position.
REQ-023 player_mask SHALL always equal one-hot decode of {player_y,player_x}; never zero, never multi-hot.
REQ-024 frame_tick ignored in CHECK and MOVE; not queued.
REQ-025 Start cell is not wall-checked; player placed at START even if wall bit set.

Reset
REQ-026 rst=1 asynchronously forces state IDLE, player_x=START_X, player_y=START_Y, player_mask bit START_Y*8+START_X only, busy=0, bump=0, frame counter 0, latched direction cleared.
REQ-027 rst mid-CHECK or mid-MOVE aborts move; no position update, no bump pulse.
REQ-028 First move possible on first frame_tick after rst deasserts.

Verification
REQ-029 Reset, no buttons, 10 frame_ticks -> player (1,1), mask bit 9 only, busy=0 throughout.
REQ-030 From (1,1), open cell (2,1), btn_right held, frame_tick pulse -> CHECK, MOVE, player_x=2 two clocks later, mask bit 10, bump never high.
REQ-031 From (1,1), grid_is_wall bit 1 set, btn_up, frame_tick -> bump=1 one cycle in CHECK, position stays (1,1).
REQ-032 Player at (0,3), btn_left, frame_tick -> edge rejection, bump pulse, x remains 0, no wrap to 7.
REQ-033 HOLD_FRAMES=8, btn_down held with open column -> one move per 8 frame_ticks after first; release during HOLD -> IDLE next clock, no further move.
REQ-034 btn_up and btn_right both high, frame_tick -> up taken; rst asserted in CHECK -> outputs at reset values same cycle, no bump.
